// File: rtl/display_timing_gen.sv
// Display timing generator: raster position, sync, data enable, line/frame/animate
// strobes and a completed-frame counter, all registered with zero relative latency.
module display_timing_gen #(
    parameter int CORDW  = 10,
    parameter int H_RES  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_RES  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int H_POL  = 0,
    parameter int V_POL  = 0,
    parameter int FCW    = 16
) (
    input  logic             clk_pix,
    input  logic             rst,
    output logic [CORDW-1:0] sx,
    output logic [CORDW-1:0] sy,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic             line,
    output logic             frame,
    output logic             animate,
    output logic [FCW-1:0]   frame_cnt
);

    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;

    localparam logic [CORDW-1:0] H_LAST     = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST     = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] H_ACTIVE   = CORDW'(H_RES);
    localparam logic [CORDW-1:0] V_ACTIVE   = CORDW'(V_RES);
    localparam logic [CORDW-1:0] HS_FIRST   = CORDW'(H_RES + H_FP);
    localparam logic [CORDW-1:0] HS_LAST    = CORDW'(H_RES + H_FP + H_SYNC - 1);
    localparam logic [CORDW-1:0] VS_FIRST   = CORDW'(V_RES + V_FP);
    localparam logic [CORDW-1:0] VS_LAST    = CORDW'(V_RES + V_FP + V_SYNC - 1);
    localparam logic             H_ACT_LVL  = (H_POL != 0);
    localparam logic             V_ACT_LVL  = (V_POL != 0);

    logic [CORDW-1:0] sx_q, sx_d;
    logic [CORDW-1:0] sy_q, sy_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic             animate_q, animate_d;
    logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
    logic             first_q, first_d;

    // Decode flags from the next position so they register alongside it.
    always_comb begin
        sx_d        = sx_q + 1'b1;
        sy_d        = sy_q;
        frame_cnt_d = frame_cnt_q;
        first_d     = first_q;

        if (sx_q == H_LAST) begin
            sx_d = '0;
            sy_d = (sy_q == V_LAST) ? '0 : sy_q + 1'b1;
        end

        hsync_d   = ((sx_d >= HS_FIRST) && (sx_d <= HS_LAST)) ? H_ACT_LVL : ~H_ACT_LVL;
        vsync_d   = ((sy_d >= VS_FIRST) && (sy_d <= VS_LAST)) ? V_ACT_LVL : ~V_ACT_LVL;
        de_d      = (sx_d < H_ACTIVE) && (sy_d < V_ACTIVE);
        line_d    = (sx_d == '0);
        frame_d   = line_d && (sy_d == '0);
        animate_d = line_d && (sy_d == V_ACTIVE);

        // The frame that starts right after reset is not a completed frame.
        if (frame_d) begin
            if (first_q) begin
                first_d = 1'b0;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst) begin
            sx_q        <= H_LAST;
            sy_q        <= V_LAST;
            hsync_q     <= ~H_ACT_LVL;
            vsync_q     <= ~V_ACT_LVL;
            de_q        <= 1'b0;
            line_q      <= 1'b0;
            frame_q     <= 1'b0;
            animate_q   <= 1'b0;
            frame_cnt_q <= '0;
            first_q     <= 1'b1;
        end else begin
            sx_q        <= sx_d;
            sy_q        <= sy_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            de_q        <= de_d;
            line_q      <= line_d;
            frame_q     <= frame_d;
            animate_q   <= animate_d;
            frame_cnt_q <= frame_cnt_d;
            first_q     <= first_d;
        end
    end

    assign sx        = sx_q;
    assign sy        = sy_q;
    assign hsync     = hsync_q;
    assign vsync     = vsync_q;
    assign de        = de_q;
    assign line      = line_q;
    assign frame     = frame_q;
    assign animate   = animate_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Bench for display_timing_gen: a default 640x480 instance and a tiny high-polarity
// instance, both compared every cycle against a position-from-elapsed-cycles model.
module tb_display_timing_gen;

    // Tiny instance timing: 25 x 14 totals, 350 cycles per frame.
    localparam int B_HRES = 16, B_HFP = 2, B_HSW = 3, B_HBP = 4;
    localparam int B_VRES = 8,  B_VFP = 1, B_VSW = 2, B_VBP = 3;
    localparam int B_HT = B_HRES + B_HFP + B_HSW + B_HBP;
    localparam int B_VT = B_VRES + B_VFP + B_VSW + B_VBP;

    logic       clk_pix;
    logic       rst_a, rst_b;
    logic [9:0] sx_a, sy_a;
    logic       hsync_a, vsync_a, de_a, line_a, frame_a, animate_a;
    logic [15:0] cnt_a;
    logic [4:0] sx_b, sy_b;
    logic       hsync_b, vsync_b, de_b, line_b, frame_b, animate_b;
    logic [1:0] cnt_b;

    int errors = 0;
    int checks = 0;
    int ta, tb;

    display_timing_gen dut_a (
        .clk_pix(clk_pix), .rst(rst_a), .sx(sx_a), .sy(sy_a),
        .hsync(hsync_a), .vsync(vsync_a), .de(de_a), .line(line_a),
        .frame(frame_a), .animate(animate_a), .frame_cnt(cnt_a)
    );

    display_timing_gen #(
        .CORDW(5), .H_RES(B_HRES), .H_FP(B_HFP), .H_SYNC(B_HSW), .H_BP(B_HBP),
        .V_RES(B_VRES), .V_FP(B_VFP), .V_SYNC(B_VSW), .V_BP(B_VBP),
        .H_POL(1), .V_POL(1), .FCW(2)
    ) dut_b (
        .clk_pix(clk_pix), .rst(rst_b), .sx(sx_b), .sy(sy_b),
        .hsync(hsync_b), .vsync(vsync_b), .de(de_b), .line(line_b),
        .frame(frame_b), .animate(animate_b), .frame_cnt(cnt_b)
    );

    initial clk_pix = 1'b0;
    always #5 clk_pix = ~clk_pix;

    task automatic chk(input string name, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // t = cycles since the first edge after reset release (-1 while in reset).
    task automatic check_dut(input string tag, input int t,
                             input int hres, input int hfp, input int hsw, input int hbp,
                             input int vres, input int vfp, input int vsw, input int vbp,
                             input int hpol, input int vpol, input int fcw,
                             input int sx, input int sy, input int hs, input int vs,
                             input int de_o, input int ln, input int fr, input int an,
                             input int cnt);
        int ht, vt, ex, ey, ef;
        int e_hs, e_vs, e_de, e_ln, e_fr, e_an, e_cnt;
        ht = hres + hfp + hsw + hbp;
        vt = vres + vfp + vsw + vbp;
        if (t < 0) begin
            ex = ht - 1; ey = vt - 1;
            e_de = 0; e_ln = 0; e_fr = 0; e_an = 0; e_cnt = 0;
            e_hs = (hpol == 0) ? 1 : 0;
            e_vs = (vpol == 0) ? 1 : 0;
        end else begin
            ex = t % ht;
            ey = (t / ht) % vt;
            ef = t / (ht * vt);
            e_cnt = ef % (1 << fcw);
            e_de = (ex < hres && ey < vres) ? 1 : 0;
            e_ln = (ex == 0) ? 1 : 0;
            e_fr = (ex == 0 && ey == 0) ? 1 : 0;
            e_an = (ex == 0 && ey == vres) ? 1 : 0;
            e_hs = (ex >= hres + hfp && ex < hres + hfp + hsw) ? hpol : 1 - hpol;
            e_vs = (ey >= vres + vfp && ey < vres + vfp + vsw) ? vpol : 1 - vpol;
        end
        chk({tag, ".sx"}, sx, ex);
        chk({tag, ".sy"}, sy, ey);
        chk({tag, ".hsync"}, hs, e_hs);
        chk({tag, ".vsync"}, vs, e_vs);
        chk({tag, ".de"}, de_o, e_de);
        chk({tag, ".line"}, ln, e_ln);
        chk({tag, ".frame"}, fr, e_fr);
        chk({tag, ".animate"}, an, e_an);
        chk({tag, ".frame_cnt"}, cnt, e_cnt);
    endtask

    task automatic step();
        @(posedge clk_pix);
        #1;
        ta = rst_a ? -1 : ta + 1;
        tb = rst_b ? -1 : tb + 1;
        check_dut("a", ta, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 16,
                  int'(sx_a), int'(sy_a), int'(hsync_a), int'(vsync_a), int'(de_a),
                  int'(line_a), int'(frame_a), int'(animate_a), int'(cnt_a));
        check_dut("b", tb, B_HRES, B_HFP, B_HSW, B_HBP, B_VRES, B_VFP, B_VSW, B_VBP, 1, 1, 2,
                  int'(sx_b), int'(sy_b), int'(hsync_b), int'(vsync_b), int'(de_b),
                  int'(line_b), int'(frame_b), int'(animate_b), int'(cnt_b));
    endtask

    initial begin
        int de_cnt_a, hs_cnt_a;
        int ln_cnt_b, an_cnt_b, fr_cnt_b, de_cnt_b, vs_cnt_b;
        int guard, target;

        ta = -1; tb = -1;
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) step();

        // Release both together; tally one line of A and one frame of B.
        rst_a = 1'b0; rst_b = 1'b0;
        de_cnt_a = 0; hs_cnt_a = 0;
        ln_cnt_b = 0; an_cnt_b = 0; fr_cnt_b = 0; de_cnt_b = 0; vs_cnt_b = 0;
        for (int i = 0; i < 800; i++) begin
            step();
            if (de_a) de_cnt_a++;
            if (!hsync_a) hs_cnt_a++;
            if (i < B_HT * B_VT) begin
                if (line_b) ln_cnt_b++;
                if (animate_b) an_cnt_b++;
                if (frame_b) fr_cnt_b++;
                if (de_b) de_cnt_b++;
                if (vsync_b) vs_cnt_b++;
            end
        end
        chk("a.de_cycles_per_line", de_cnt_a, 640);
        chk("a.hsync_cycles_per_line", hs_cnt_a, 96);
        chk("b.lines_per_frame", ln_cnt_b, B_VT);
        chk("b.animate_per_frame", an_cnt_b, 1);
        chk("b.frames_per_frame", fr_cnt_b, 1);
        chk("b.de_cycles_per_frame", de_cnt_b, B_HRES * B_VRES);
        chk("b.vsync_cycles_per_frame", vs_cnt_b, B_VSW * B_HT);

        // Run B through several frames so its 2-bit counter wraps.
        repeat (1500) step();

        // Single-cycle reset of A mid-line at sx=300.
        guard = 0;
        while ((ta % 800) != 300 && guard < 2000) begin
            step();
            guard++;
        end
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        step();

        // Single-cycle reset of B at a random raster position.
        target = int'($urandom_range(1, B_HT * B_VT - 1));
        guard = 0;
        while ((tb % (B_HT * B_VT)) != target && guard < 1000) begin
            step();
            guard++;
        end
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        step();

        // Random reset pulses of varying length on both instances.
        for (int i = 0; i < 3000; i++) begin
            rst_a = ($urandom_range(0, 999) == 0);
            rst_b = ($urandom_range(0, 99) < 3);
            step();
        end
        rst_a = 1'b0; rst_b = 1'b0;
        repeat (400) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
